// File: rtl/washing_machine_ctrl_param.sv
// Parametrised washing-machine sequencer: FILL/WASH/RINSE(xN)/SPIN/DRY or STEAM-only,
// with seconds prescaler, pause, door-error resume from saved context, abort and status outputs.
module washing_machine_ctrl_param #(
  parameter int TICKS_PER_SEC = 1,
  parameter int CNT_W         = 8,
  parameter int T_FILL        = 10,
  parameter int T_WASH        = 50,
  parameter int T_RINSE       = 50,
  parameter int T_SPIN        = 20,
  parameter int T_DRY         = 60,
  parameter int T_STEAM       = 60,
  parameter int EXTRA_PASSES  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             double_wash_i,
  input  logic             dry_wash_i,
  input  logic             time_pause_i,
  input  logic             door_closed_i,
  input  logic             abort_i,
  output logic             done_o,
  output logic             error_signal_o,
  output logic [2:0]       phase_o,
  output logic [CNT_W-1:0] time_left_o
);

  localparam int    PRE_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int    PASS_W = (EXTRA_PASSES > 1) ? $clog2(EXTRA_PASSES + 1) : 1;
  localparam longint TMAX  = (64'd1 << CNT_W) - 64'd1;

  if (TICKS_PER_SEC < 1 || EXTRA_PASSES < 1 ||
      T_FILL  < 1 || T_FILL  > TMAX || T_WASH < 1 || T_WASH > TMAX ||
      T_RINSE < 1 || T_RINSE > TMAX || T_SPIN < 1 || T_SPIN > TMAX ||
      T_DRY   < 1 || T_DRY   > TMAX || T_STEAM < 1 || T_STEAM > TMAX) begin : g_bad_params
    $error("washing_machine_ctrl_param: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_SPIN  = 3'd4,
    S_DRY   = 3'd5,
    S_STEAM = 3'd6,
    S_ERROR = 3'd7
  } state_e;

  function automatic logic [CNT_W-1:0] phase_dur(input state_e s);
    case (s)
      S_FILL:  phase_dur = CNT_W'(T_FILL);
      S_WASH:  phase_dur = CNT_W'(T_WASH);
      S_RINSE: phase_dur = CNT_W'(T_RINSE);
      S_SPIN:  phase_dur = CNT_W'(T_SPIN);
      S_DRY:   phase_dur = CNT_W'(T_DRY);
      S_STEAM: phase_dur = CNT_W'(T_STEAM);
      default: phase_dur = '0;
    endcase
  endfunction

  state_e              state_q, state_d, sv_state_q, sv_state_d;
  logic [CNT_W-1:0]    sec_q, sec_d, sv_sec_q, sv_sec_d;
  logic [PRE_W-1:0]    pre_q, pre_d, sv_pre_q, sv_pre_d;
  logic [PASS_W-1:0]   passes_q, passes_d, sv_passes_q, sv_passes_d;
  logic                done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]    tl_q, tl_d;
  logic                tick_s, last_sec_s;

  assign tick_s     = (pre_q == PRE_W'(TICKS_PER_SEC - 1));
  assign last_sec_s = (sec_q == phase_dur(state_q) - CNT_W'(1));

  // State, counter, saved-context and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sec_q       <= '0;
      pre_q       <= '0;
      passes_q    <= '0;
      sv_state_q  <= S_IDLE;
      sv_sec_q    <= '0;
      sv_pre_q    <= '0;
      sv_passes_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tl_q        <= '0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      pre_q       <= pre_d;
      passes_q    <= passes_d;
      sv_state_q  <= sv_state_d;
      sv_sec_q    <= sv_sec_d;
      sv_pre_q    <= sv_pre_d;
      sv_passes_q <= sv_passes_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tl_q        <= tl_d;
    end
  end

  // Next-state: abort > door > pause > tick/phase-end
  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    pre_d       = pre_q;
    passes_d    = passes_q;
    sv_state_d  = sv_state_q;
    sv_sec_d    = sv_sec_q;
    sv_pre_d    = sv_pre_q;
    sv_passes_d = sv_passes_q;
    done_d      = done_q;
    if (abort_i) begin
      state_d     = S_IDLE;
      sec_d       = '0;
      pre_d       = '0;
      passes_d    = '0;
      sv_state_d  = S_IDLE;
      sv_sec_d    = '0;
      sv_pre_d    = '0;
      sv_passes_d = '0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sec_d = '0;
          pre_d = '0;
          if (start_i && door_closed_i) begin
            state_d  = dry_wash_i ? S_STEAM : S_FILL;
            done_d   = 1'b0;
            passes_d = double_wash_i ? PASS_W'(EXTRA_PASSES) : '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ERROR: begin
          if (door_closed_i) begin
            state_d  = sv_state_q;
            sec_d    = sv_sec_q;
            pre_d    = sv_pre_q;
            passes_d = sv_passes_q;
          end else begin
            state_d = S_ERROR;
          end
        end
        default: begin
          if (!door_closed_i) begin
            // The completing tick of this edge is dropped; resume re-runs it.
            sv_state_d  = state_q;
            sv_sec_d    = sec_q;
            sv_pre_d    = pre_q;
            sv_passes_d = passes_q;
            state_d     = S_ERROR;
          end else if (time_pause_i) begin
            state_d = state_q;
          end else if (tick_s) begin
            pre_d = '0;
            if (last_sec_s) begin
              sec_d = '0;
              case (state_q)
                S_FILL:  state_d = S_WASH;
                S_WASH:  state_d = S_RINSE;
                S_RINSE: begin
                  if (passes_q != '0) begin
                    state_d  = S_WASH;
                    passes_d = passes_q - PASS_W'(1);
                  end else begin
                    state_d = S_SPIN;
                  end
                end
                S_SPIN:  state_d = S_DRY;
                S_DRY, S_STEAM: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
              endcase
            end else begin
              sec_d = sec_q + CNT_W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      endcase
    end
  end

  // Status outputs, computed from next state so the registered copies line up with phase
  always_comb begin
    err_d = (state_d == S_ERROR);
    if (state_d == S_ERROR) begin
      tl_d = phase_dur(sv_state_d) - sv_sec_d;
    end else if (state_d == S_IDLE) begin
      tl_d = '0;
    end else begin
      tl_d = phase_dur(state_d) - sec_d;
    end
  end

  assign phase_o        = state_q;
  assign done_o         = done_q;
  assign error_signal_o = err_q;
  assign time_left_o    = tl_q;

endmodule

// File: tb/tb_washing_machine_ctrl_param.sv
// Bench for washing_machine_ctrl_param: directed scenarios plus randomized stimulus,
// checked against a queue-of-phases reference model (DUT u1, one tick per clock).
module tb_washing_machine_ctrl_param;
  localparam int EXTRA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, dbl = 1'b0, dry = 1'b0;
  logic pause = 1'b0, door = 1'b1, abort = 1'b0;
  logic done1, err1, done2, err2;
  logic [2:0] ph1, ph2;
  logic [7:0] tl1, tl2;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  washing_machine_ctrl_param #(.TICKS_PER_SEC(1), .EXTRA_PASSES(EXTRA)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .double_wash_i(dbl), .dry_wash_i(dry),
    .time_pause_i(pause), .door_closed_i(door), .abort_i(abort),
    .done_o(done1), .error_signal_o(err1), .phase_o(ph1), .time_left_o(tl1));

  washing_machine_ctrl_param #(.TICKS_PER_SEC(4)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .double_wash_i(dbl), .dry_wash_i(dry),
    .time_pause_i(pause), .door_closed_i(door), .abort_i(abort),
    .done_o(done2), .error_signal_o(err2), .phase_o(ph2), .time_left_o(tl2));

  // Reference model: a programme is a queue of phases; elapsed seconds within current phase.
  int m_phase = 0, m_el = 0;
  bit m_err = 1'b0, m_done = 1'b0;
  int m_q[$];

  function automatic int mdur(input int p);
    case (p)
      1: return 10;
      2: return 50;
      3: return 50;
      4: return 20;
      5: return 60;
      6: return 60;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    if (rst || abort) begin
      m_phase = 0; m_el = 0; m_err = 1'b0; m_done = 1'b0; m_q.delete();
    end else if (m_phase == 0) begin
      if (start && door) begin
        m_q.delete();
        if (dry) m_q.push_back(6);
        else begin
          m_q.push_back(1);
          for (int i = 0; i < (dbl ? EXTRA + 1 : 1); i++) begin
            m_q.push_back(2); m_q.push_back(3);
          end
          m_q.push_back(4); m_q.push_back(5);
        end
        m_phase = m_q.pop_front(); m_el = 0; m_done = 1'b0;
      end
    end else if (m_err) begin
      if (door) m_err = 1'b0;
    end else if (!door) begin
      m_err = 1'b1;
    end else if (!pause) begin
      m_el++;
      if (m_el == mdur(m_phase)) begin
        m_el = 0;
        if (m_q.size() == 0) begin m_phase = 0; m_done = 1'b1; end
        else m_phase = m_q.pop_front();
      end
    end
  endtask

  function automatic logic [12:0] exp_vec();
    logic [2:0] p;
    logic [7:0] t;
    p = m_err ? 3'd7 : 3'(m_phase);
    t = (m_phase == 0) ? 8'd0 : 8'(mdur(m_phase) - m_el);
    return {p, t, m_done, m_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst = 1'b1; start = 1'b1; door = 1'b1;
    repeat (5) begin
      tick();
      e = exp_vec();
      if ({ph1, tl1, done1, err1} !== e) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got ph=%0d tl=%0d done=%b err=%b want ph=%0d tl=%0d done=%b err=%b",
                 cyc, ph1, tl1, done1, err1, e[12:10], e[9:2], e[1], e[0]);
      end
      n_cmp++;
    end
    rst = 1'b0;
    tick();
    if (ph1 !== 3'd1) begin
      n_bad++;
      $display("FAIL reset_release got ph=%0d want ph=1", ph1);
    end
    n_cmp++;
    start = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_normal();
    logic [12:0] e;
    int n;
    start = 1'b1; dbl = 1'b0; dry = 1'b0;
    tick();
    start = 1'b0; n = 0;
    while (done1 !== 1'b1 && n < 400) begin
      tick(); n++;
      e = exp_vec();
      if ({ph1, tl1, done1, err1} !== e) begin
        n_bad++;
        $display("FAIL normal cyc=%0d got ph=%0d tl=%0d done=%b err=%b want ph=%0d tl=%0d done=%b err=%b",
                 cyc, ph1, tl1, done1, err1, e[12:10], e[9:2], e[1], e[0]);
      end
      n_cmp++;
    end
    if (n !== 190) begin
      n_bad++;
      $display("FAIL normal_len got %0d cycles want 190", n);
    end
    n_cmp++;
    repeat (10) begin
      dbl = 1'($urandom); dry = 1'($urandom);
      tick();
      if (done1 !== 1'b1 || ph1 !== 3'd0) begin
        n_bad++;
        $display("FAIL done_hold got done=%b ph=%0d want done=1 ph=0", done1, ph1);
      end
      n_cmp++;
    end
    dbl = 1'b0; dry = 1'b0;
  endtask

  task automatic test_double_wash();
    logic [12:0] e;
    int n, washes;
    logic [2:0] prev;
    start = 1'b1; dbl = 1'b1;
    tick();
    start = 1'b0; n = 0; washes = 0; prev = ph1;
    while (ph1 !== 3'd4 && n < 600) begin
      dbl = 1'($urandom);
      tick(); n++;
      if (ph1 === 3'd2 && prev !== 3'd2) washes++;
      prev = ph1;
      e = exp_vec();
      if ({ph1, tl1, done1, err1} !== e) begin
        n_bad++;
        $display("FAIL double cyc=%0d got ph=%0d tl=%0d done=%b err=%b want ph=%0d tl=%0d done=%b err=%b",
                 cyc, ph1, tl1, done1, err1, e[12:10], e[9:2], e[1], e[0]);
      end
      n_cmp++;
    end
    if (n !== 310 || washes !== 3) begin
      n_bad++;
      $display("FAIL double_len got %0d cycles %0d washes want 310 cycles 3 washes", n, washes);
    end
    n_cmp++;
    dbl = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_pause();
    logic [12:0] e;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    pause = 1'b1;
    repeat (3) begin
      tick();
      if (ph1 !== 3'd1 || tl1 !== 8'd5) begin
        n_bad++;
        $display("FAIL pause_hold got ph=%0d tl=%0d want ph=1 tl=5", ph1, tl1);
      end
      n_cmp++;
    end
    pause = 1'b0; n = 3;
    while (ph1 !== 3'd2 && n < 50) begin
      tick(); n++;
      e = exp_vec();
      if ({ph1, tl1, done1, err1} !== e) begin
        n_bad++;
        $display("FAIL pause cyc=%0d got ph=%0d tl=%0d done=%b err=%b want ph=%0d tl=%0d done=%b err=%b",
                 cyc, ph1, tl1, done1, err1, e[12:10], e[9:2], e[1], e[0]);
      end
      n_cmp++;
    end
    if (n !== 3 + 5) begin
      n_bad++;
      $display("FAIL pause_len got %0d want 8", n);
    end
    n_cmp++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_door_error();
    logic [12:0] e;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    door = 1'b0;
    repeat ($urandom_range(1, 5)) begin
      pause = 1'($urandom);
      tick();
      if (ph1 !== 3'd7 || err1 !== 1'b1 || tl1 !== 8'd30) begin
        n_bad++;
        $display("FAIL door_err got ph=%0d err=%b tl=%0d want ph=7 err=1 tl=30", ph1, err1, tl1);
      end
      n_cmp++;
    end
    pause = 1'b0; door = 1'b1;
    tick();
    if (ph1 !== 3'd2 || err1 !== 1'b0 || tl1 !== 8'd30) begin
      n_bad++;
      $display("FAIL door_resume got ph=%0d err=%b tl=%0d want ph=2 err=0 tl=30", ph1, err1, tl1);
    end
    n_cmp++;
    tick();
    if (tl1 !== 8'd29) begin
      n_bad++;
      $display("FAIL door_count got tl=%0d want 29", tl1);
    end
    n_cmp++;
    repeat (28) tick();
    door = 1'b0;
    repeat (2) begin
      tick();
      e = exp_vec();
      if ({ph1, tl1, done1, err1} !== e) begin
        n_bad++;
        $display("FAIL door_edge cyc=%0d got ph=%0d tl=%0d done=%b err=%b want ph=%0d tl=%0d done=%b err=%b",
                 cyc, ph1, tl1, done1, err1, e[12:10], e[9:2], e[1], e[0]);
      end
      n_cmp++;
      door = 1'b1;
    end
    tick();
    if (ph1 !== 3'd3) begin
      n_bad++;
      $display("FAIL door_edge_next got ph=%0d want 3", ph1);
    end
    n_cmp++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [12:0] e;
    start = 1'b1; dry = 1'b1;
    tick();
    start = 1'b0; dry = 1'b0;
    repeat (30) tick();
    if (ph1 !== 3'd6 || tl1 !== 8'd30) begin
      n_bad++;
      $display("FAIL steam got ph=%0d tl=%0d want ph=6 tl=30", ph1, tl1);
    end
    n_cmp++;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    e = exp_vec();
    if ({ph1, tl1, done1, err1} !== e || ph1 !== 3'd0 || done1 !== 1'b0) begin
      n_bad++;
      $display("FAIL abort got ph=%0d tl=%0d done=%b err=%b want ph=0 tl=0 done=0 err=0",
               ph1, tl1, done1, err1);
    end
    n_cmp++;
  endtask

  task automatic test_prescaler();
    int n;
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0; n = 0;
    while (ph2 === 3'd1 && n < 100) begin
      if (tl2 !== 8'(10 - n / 4)) begin
        n_bad++;
        $display("FAIL presc_tl n=%0d got tl=%0d want %0d", n, tl2, 10 - n / 4);
      end
      n_cmp++;
      tick(); n++;
    end
    if (n !== 40 || ph2 !== 3'd2) begin
      n_bad++;
      $display("FAIL presc_len got %0d cycles ph=%0d want 40 cycles ph=2", n, ph2);
    end
    n_cmp++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_random();
    logic [12:0] e;
    repeat (4000) begin
      start = ($urandom % 8) == 0;
      dbl   = 1'($urandom);
      dry   = ($urandom % 4) == 0;
      pause = ($urandom % 6) == 0;
      door  = ($urandom % 25) != 0;
      abort = ($urandom % 700) == 0;
      rst   = ($urandom % 1500) == 0;
      tick();
      e = exp_vec();
      if ({ph1, tl1, done1, err1} !== e) begin
        n_bad++;
        $display("FAIL random cyc=%0d got ph=%0d tl=%0d done=%b err=%b want ph=%0d tl=%0d done=%b err=%b",
                 cyc, ph1, tl1, done1, err1, e[12:10], e[9:2], e[1], e[0]);
      end
      n_cmp++;
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0; pause = 1'b0; door = 1'b1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_double_wash();
    test_pause();
    test_door_error();
    test_abort();
    test_prescaler();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout after %0d cycles", cyc);
    $fatal(1, "timeout");
  end
endmodule
